// File: rtl/chacha_aead_seq_if.sv
// Bus bundle between the ChaCha20-Poly1305 AEAD sequencer, its host and its crypto core.
// The master modport is the host/core side and the slave modport is the sequencer side.
interface chacha_aead_seq_if;
    logic         start;
    logic [15:0]  aad_len;
    logic [15:0]  pld_len;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         cfg_we;
    logic         ks_req;
    logic         ks_valid;
    logic         aad_valid;
    logic [127:0] aad_data;
    logic [15:0]  aad_keep;
    logic         aad_ready;
    logic         aad_done;
    logic         pld_valid;
    logic [127:0] pld_data;
    logic [15:0]  pld_keep;
    logic         pld_ready;
    logic         pld_done;
    logic         len_valid;
    logic [127:0] len_block;
    logic         len_ready;
    logic         lens_done;
    logic         tag_pre_xor_valid;
    logic         tagmask_valid;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output start, aad_len, pld_len, in_valid, in_data,
        output ks_valid, aad_ready, aad_done, pld_ready, pld_done,
        output len_ready, lens_done, tag_pre_xor_valid, tagmask_valid,
        input  in_ready, cfg_we, ks_req, aad_valid, aad_data, aad_keep,
        input  pld_valid, pld_data, pld_keep, len_valid, len_block,
        input  busy, done, err
    );

    modport slave (
        input  start, aad_len, pld_len, in_valid, in_data,
        input  ks_valid, aad_ready, aad_done, pld_ready, pld_done,
        input  len_ready, lens_done, tag_pre_xor_valid, tagmask_valid,
        output in_ready, cfg_we, ks_req, aad_valid, aad_data, aad_keep,
        output pld_valid, pld_data, pld_keep, len_valid, len_block,
        output busy, done, err
    );
endinterface

// File: rtl/chacha_aead_seq.sv
// ChaCha20-Poly1305 AEAD message sequencer: configures the core, requests keystream,
// streams AAD then payload blocks, issues the length block and waits for the tag.
// Optional watchdog: define CHACHA_SEQ_TIMEOUT_EN to abort stalled wait states with err.
module chacha_aead_seq (
    input  logic             clk,
    input  logic             rst_n,
    chacha_aead_seq_if.slave bus
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CFG      = 4'd1;
    localparam logic [3:0] S_KS_REQ   = 4'd2;
    localparam logic [3:0] S_KS_WAIT  = 4'd3;
    localparam logic [3:0] S_AAD      = 4'd4;
    localparam logic [3:0] S_AAD_WAIT = 4'd5;
    localparam logic [3:0] S_PLD      = 4'd6;
    localparam logic [3:0] S_PLD_WAIT = 4'd7;
    localparam logic [3:0] S_LEN      = 4'd8;
    localparam logic [3:0] S_LEN_WAIT = 4'd9;
    localparam logic [3:0] S_TAG_WAIT = 4'd10;
    localparam logic [3:0] S_DONE     = 4'd11;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [15:0] r_aadLen;
    logic [15:0] r_pldLen;
    logic [15:0] r_aadRem;
    logic [15:0] r_pldRem;
    logic [11:0] r_blkIdx;
    logic        r_doneSeen;
    logic        r_tagPre;
    logic        r_tagMask;
    logic        w_aadXfer;
    logic        w_pldXfer;
    logic        w_lenXfer;
    logic        w_tagPre;
    logic        w_tagMask;
    logic        w_timeout;

    // Valid-byte mask for the block holding the next rem bytes.
    function automatic logic [15:0] keepOf(input logic [15:0] rem);
        if (rem >= 16'd16) return 16'hFFFF;
        return (16'h1 << rem[3:0]) - 16'h1;
    endfunction

    // Bytes consumed by one block transfer.
    function automatic logic [15:0] stepOf(input logic [15:0] rem);
        return (rem >= 16'd16) ? 16'd16 : rem;
    endfunction

    assign w_aadXfer = (r_state == S_AAD) && bus.in_valid && bus.aad_ready;
    assign w_pldXfer = (r_state == S_PLD) && bus.in_valid && bus.pld_ready;
    assign w_lenXfer = (r_state == S_LEN) && bus.len_ready;
    assign w_tagPre  = r_tagPre  || bus.tag_pre_xor_valid;
    assign w_tagMask = r_tagMask || bus.tagmask_valid;

`ifdef CHACHA_SEQ_TIMEOUT_EN
    logic [15:0] r_wdog;
    logic        w_isWait;

    assign w_isWait  = (r_state == S_KS_WAIT)  || (r_state == S_AAD_WAIT) ||
                       (r_state == S_PLD_WAIT) || (r_state == S_LEN_WAIT) ||
                       (r_state == S_TAG_WAIT);
    assign w_timeout = w_isWait && (r_wdog == 16'hFFFF);

    // Watchdog counts cycles spent in a wait state and restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_wdog <= 16'h0;
        else if (w_next != r_state) r_wdog <= 16'h0;
        else if (w_isWait)          r_wdog <= r_wdog + 16'h1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state selection; a watchdog expiry overrides everything and drops to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_next = S_CFG;
            S_CFG:      w_next = S_KS_REQ;
            S_KS_REQ:   w_next = S_KS_WAIT;
            S_KS_WAIT: begin
                if (bus.ks_valid) begin
                    if (r_blkIdx != 12'd0)       w_next = S_PLD;
                    else if (r_aadLen != 16'd0)  w_next = S_AAD;
                    else if (r_pldLen != 16'd0)  w_next = S_PLD;
                    else                         w_next = S_LEN;
                end
            end
            S_AAD:      if (w_aadXfer) w_next = S_AAD_WAIT;
            S_AAD_WAIT: begin
                if (bus.aad_done || r_doneSeen) begin
                    if (r_aadRem != 16'd0)      w_next = S_AAD;
                    else if (r_pldLen != 16'd0) w_next = S_PLD;
                    else                        w_next = S_LEN;
                end
            end
            S_PLD:      if (w_pldXfer) w_next = S_PLD_WAIT;
            S_PLD_WAIT: begin
                if (bus.pld_done || r_doneSeen) begin
                    if (r_pldRem == 16'd0)         w_next = S_LEN;
                    else if (r_blkIdx[1:0] == 2'd0) w_next = S_KS_REQ;
                    else                           w_next = S_PLD;
                end
            end
            S_LEN:      if (w_lenXfer) w_next = S_LEN_WAIT;
            S_LEN_WAIT: if (bus.lens_done || r_doneSeen) w_next = S_TAG_WAIT;
            S_TAG_WAIT: if (w_tagPre && w_tagMask) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_IDLE;
    end

    // State register plus length capture, byte/block counters and completion latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_aadLen   <= 16'h0;
            r_pldLen   <= 16'h0;
            r_aadRem   <= 16'h0;
            r_pldRem   <= 16'h0;
            r_blkIdx   <= 12'h0;
            r_doneSeen <= 1'b0;
            r_tagPre   <= 1'b0;
            r_tagMask  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_aadLen   <= bus.aad_len;
                        r_pldLen   <= bus.pld_len;
                        r_aadRem   <= bus.aad_len;
                        r_pldRem   <= bus.pld_len;
                        r_blkIdx   <= 12'h0;
                        r_doneSeen <= 1'b0;
                        r_tagPre   <= 1'b0;
                        r_tagMask  <= 1'b0;
                    end
                end
                S_AAD: begin
                    if (w_aadXfer) begin
                        r_aadRem   <= r_aadRem - stepOf(r_aadRem);
                        r_doneSeen <= bus.aad_done;
                    end
                end
                S_PLD: begin
                    if (w_pldXfer) begin
                        r_pldRem   <= r_pldRem - stepOf(r_pldRem);
                        r_blkIdx   <= r_blkIdx + 12'h1;
                        r_doneSeen <= bus.pld_done;
                    end
                end
                S_LEN: begin
                    if (w_lenXfer) r_doneSeen <= bus.lens_done;
                end
                S_AAD_WAIT, S_PLD_WAIT: r_doneSeen <= 1'b0;
                S_LEN_WAIT: begin
                    r_doneSeen <= 1'b0;
                    r_tagPre   <= w_tagPre;
                    r_tagMask  <= w_tagMask;
                end
                S_TAG_WAIT: begin
                    r_tagPre  <= w_tagPre;
                    r_tagMask <= w_tagMask;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the state so reset silences them immediately.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.ks_req    = 1'b0;
        bus.aad_valid = 1'b0;
        bus.aad_data  = 128'h0;
        bus.aad_keep  = 16'h0;
        bus.pld_valid = 1'b0;
        bus.pld_data  = 128'h0;
        bus.pld_keep  = 16'h0;
        bus.len_valid = 1'b0;
        bus.len_block = 128'h0;
        bus.done      = 1'b0;
        case (r_state)
            S_CFG:    bus.cfg_we = 1'b1;
            S_KS_REQ: bus.ks_req = 1'b1;
            S_AAD: begin
                bus.aad_valid = bus.in_valid;
                bus.aad_data  = bus.in_data;
                bus.aad_keep  = keepOf(r_aadRem);
                bus.in_ready  = bus.aad_ready;
            end
            S_PLD: begin
                bus.pld_valid = bus.in_valid;
                bus.pld_data  = bus.in_data;
                bus.pld_keep  = keepOf(r_pldRem);
                bus.in_ready  = bus.pld_ready;
            end
            S_LEN: begin
                bus.len_valid = 1'b1;
                bus.len_block = {48'h0, r_pldLen, 48'h0, r_aadLen};
            end
            S_DONE:   bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.err  = w_timeout;

endmodule

// File: tb/tb_chacha_aead_seq.sv
// Self-checking bench for chacha_aead_seq: randomized core/host timing, a message-level
// reference model (block data, keep masks, keystream count, length block) and a per-cycle
// compare process. The watchdog scenario runs only when CHACHA_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_chacha_aead_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    chacha_aead_seq_if bus();

    chacha_aead_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nChecks = 0;
    int nErrors = 0;

    int          msgId = 0;
    logic [31:0] msgSalt = 32'h0;
    int          msgAad = 0;
    int          msgPld = 0;
    logic        ksStall = 1'b0;

    int lastMsg = 0;
    int cfgCnt = 0, ksCnt = 0, doneCnt = 0, errCnt = 0;
    int inReadyCnt = 0, lenCnt = 0, aadIdx = 0, pldIdx = 0;

    int ksPend = 0, aadPend = 0, pldPend = 0, lenPend = 0, prePend = 0, maskPend = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int nBlocks(input int n);
        return (n + 15) / 16;
    endfunction

    function automatic logic [15:0] keepModel(input int rem);
        if (rem >= 16) return 16'hFFFF;
        return 16'((32'd1 << rem) - 32'd1);
    endfunction

    function automatic int expKs(input int pldBytes);
        int nb;
        nb = nBlocks(pldBytes);
        return (nb == 0) ? 1 : 1 + (nb - 1) / 4;
    endfunction

    function automatic logic [127:0] lenModel(input int aadN, input int pldN);
        return (128'(pldN) << 64) | 128'(aadN);
    endfunction

    function automatic logic [127:0] blockData(input logic [31:0] salt, input int kind, input int idx);
        logic [31:0]  x;
        logic [127:0] r;
        x = salt ^ 32'(kind << 16) ^ (32'(idx) * 32'h9E3779B1);
        r = 128'h0;
        for (int w = 0; w < 4; w++) begin
            x = (x ^ (x >> 13)) * 32'h01000193 + 32'(w);
            r[w*32 +: 32] = x;
        end
        return r;
    endfunction

    // Core ready signals change randomly just after each rising edge.
    always @(posedge clk) begin
        #1;
        bus.aad_ready = ($urandom_range(0, 3) != 0);
        bus.pld_ready = ($urandom_range(0, 3) != 0);
        bus.len_ready = ($urandom_range(0, 2) != 0);
    end

    // Core completion model: keystream, per-block done and tag pulses with random latency.
    always @(negedge clk) begin
        int d;
        if (!rst_n) begin
            bus.ks_valid = 0; bus.aad_done = 0; bus.pld_done = 0; bus.lens_done = 0;
            bus.tag_pre_xor_valid = 0; bus.tagmask_valid = 0;
            ksPend = 0; aadPend = 0; pldPend = 0; lenPend = 0; prePend = 0; maskPend = 0;
        end else begin
            bus.ks_valid = 0; bus.aad_done = 0; bus.pld_done = 0; bus.lens_done = 0;
            bus.tag_pre_xor_valid = 0; bus.tagmask_valid = 0;
            if (ksPend > 0)   begin ksPend--;   if (ksPend == 0)   bus.ks_valid = 1; end
            if (aadPend > 0)  begin aadPend--;  if (aadPend == 0)  bus.aad_done = 1; end
            if (pldPend > 0)  begin pldPend--;  if (pldPend == 0)  bus.pld_done = 1; end
            if (lenPend > 0)  begin lenPend--;  if (lenPend == 0)  bus.lens_done = 1; end
            if (prePend > 0)  begin prePend--;  if (prePend == 0)  bus.tag_pre_xor_valid = 1; end
            if (maskPend > 0) begin maskPend--; if (maskPend == 0) bus.tagmask_valid = 1; end
            if (bus.ks_req && !ksStall) ksPend = $urandom_range(1, 3);
            if (bus.aad_valid && bus.aad_ready) begin
                d = $urandom_range(0, 2);
                if (d == 0) bus.aad_done = 1; else aadPend = d;
            end
            if (bus.pld_valid && bus.pld_ready) begin
                d = $urandom_range(0, 2);
                if (d == 0) bus.pld_done = 1; else pldPend = d;
            end
            if (bus.len_valid && bus.len_ready) begin
                d = $urandom_range(0, 2);
                if (d == 0) bus.lens_done = 1; else lenPend = d;
            end
            if (bus.lens_done) begin
                prePend  = $urandom_range(1, 3);
                maskPend = $urandom_range(1, 3);
            end
        end
    end

    // Compare process: checks every transfer and idle cycle against the message model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (msgId != lastMsg) begin
                cfgCnt = 0; ksCnt = 0; doneCnt = 0; errCnt = 0;
                inReadyCnt = 0; lenCnt = 0; aadIdx = 0; pldIdx = 0;
                lastMsg = msgId;
            end
            if (bus.cfg_we)   cfgCnt++;
            if (bus.ks_req)   ksCnt++;
            if (bus.done)     doneCnt++;
            if (bus.err)      errCnt++;
            if (bus.in_ready) inReadyCnt++;
            if (!bus.busy)
                checkOutput("idle outputs",
                    {bus.in_ready, bus.cfg_we, bus.ks_req, bus.aad_valid, bus.pld_valid,
                     bus.len_valid, bus.done, bus.err, bus.aad_keep, bus.pld_keep}, 128'h0);
            if (bus.aad_valid && bus.aad_ready) begin
                if (aadIdx >= nBlocks(msgAad)) begin
                    checkOutput("aad block count", aadIdx, nBlocks(msgAad));
                end else begin
                    checkOutput("aad data", bus.aad_data, blockData(msgSalt, 0, aadIdx));
                    checkOutput("aad keep", bus.aad_keep, keepModel(msgAad - 16 * aadIdx));
                end
                aadIdx++;
            end
            if (bus.pld_valid && bus.pld_ready) begin
                if (pldIdx >= nBlocks(msgPld)) begin
                    checkOutput("pld block count", pldIdx, nBlocks(msgPld));
                end else begin
                    checkOutput("pld data", bus.pld_data, blockData(msgSalt, 1, pldIdx));
                    checkOutput("pld keep", bus.pld_keep, keepModel(msgPld - 16 * pldIdx));
                    checkOutput("ks before pld block", ksCnt, 1 + pldIdx / 4);
                end
                pldIdx++;
            end
            if (bus.len_valid && bus.len_ready) begin
                checkOutput("len block", bus.len_block, lenModel(msgAad, msgPld));
                lenCnt++;
            end
        end
    end

    task automatic sendBlock(input logic [127:0] data);
        logic acc;
        int   budget;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            budget++;
        end while (!acc && budget < 500);
        if (!acc) checkOutput("in_ready timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin @(posedge clk); #1; n++; end
    endtask

    task automatic startMessage(input int aadN, input int pldN);
        waitIdle();
        msgSalt = $urandom;
        msgAad  = aadN;
        msgPld  = pldN;
        msgId++;
        bus.start   = 1'b1;
        bus.aad_len = 16'(aadN);
        bus.pld_len = 16'(pldN);
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.aad_len = 16'($urandom);
        bus.pld_len = 16'($urandom);
    endtask

    task automatic applyStimulus(input int aadN, input int pldN);
        int n;
        startMessage(aadN, pldN);
        for (int i = 0; i < nBlocks(aadN); i++) sendBlock(blockData(msgSalt, 0, i));
        for (int i = 0; i < nBlocks(pldN); i++) sendBlock(blockData(msgSalt, 1, i));
        n = 0;
        while (doneCnt == 0 && n < 3000) begin @(posedge clk); #1; n++; end
        if (doneCnt == 0) checkOutput("done timeout", 0, 1);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("done pulses", doneCnt, 1);
        checkOutput("cfg_we pulses", cfgCnt, 1);
        checkOutput("ks_req pulses", ksCnt, expKs(pldN));
        checkOutput("err pulses", errCnt, 0);
        checkOutput("aad blocks", aadIdx, nBlocks(aadN));
        checkOutput("pld blocks", pldIdx, nBlocks(pldN));
        checkOutput("len transfers", lenCnt, 1);
        checkOutput("busy after done", bus.busy, 0);
        if (aadN == 0 && pldN == 0) checkOutput("in_ready on empty msg", inReadyCnt, 0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " busy"}, bus.busy, 0);
        checkOutput({name, " ctrl"},
            {bus.in_ready, bus.cfg_we, bus.ks_req, bus.aad_valid, bus.pld_valid,
             bus.len_valid, bus.done, bus.err}, 0);
        checkOutput({name, " keeps"}, {bus.aad_keep, bus.pld_keep}, 0);
        checkOutput({name, " data"}, bus.pld_data | bus.aad_data | bus.len_block, 0);
    endtask

    task automatic resetDuringPldWait();
        startMessage(0, 64);
        sendBlock(blockData(msgSalt, 1, 0));
        #1 rst_n = 1'b0;
        #1 checkAllZero("reset in pld_wait");
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        msgId++;
        repeat (10) begin @(posedge clk); #1; end
        checkOutput("done after reset", doneCnt, 0);
        checkOutput("err after reset", errCnt, 0);
        checkOutput("busy after reset", bus.busy, 0);
    endtask

    // Main sequence: reset, model pins, directed messages, random messages, reset abort.
    initial begin
        bus.start = 0; bus.aad_len = 0; bus.pld_len = 0;
        bus.in_valid = 0; bus.in_data = 0;
        #1 rst_n = 1'b0;
        #2 checkAllZero("reset");

        checkOutput("model keep rem5", keepModel(5), 16'h001F);
        checkOutput("model keep rem4", keepModel(4), 16'h000F);
        checkOutput("model keep rem16", keepModel(16), 16'hFFFF);
        checkOutput("model len 16/16", lenModel(16, 16), 128'h0000000000000010_0000000000000010);
        checkOutput("model len 0/20", lenModel(0, 20), 128'h0000000000000014_0000000000000000);
        checkOutput("model ks 80B", expKs(80), 2);
        checkOutput("model ks 0B", expKs(0), 1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(16, 16);
        applyStimulus(0, 20);
        applyStimulus(0, 80);
        applyStimulus(0, 0);
        applyStimulus(37, 0);
        applyStimulus(5, 129);
        for (int m = 0; m < 10; m++)
            applyStimulus($urandom_range(0, 70), $urandom_range(0, 150));

        resetDuringPldWait();
        applyStimulus(16, 40);

`ifdef CHACHA_SEQ_TIMEOUT_EN
        begin
            int n;
            ksStall = 1'b1;
            startMessage(0, 0);
            n = 0;
            while (errCnt == 0 && n < 70000) begin @(posedge clk); #1; n++; end
            repeat (3) begin @(posedge clk); #1; end
            checkOutput("watchdog err pulses", errCnt, 1);
            checkOutput("watchdog done", doneCnt, 0);
            checkOutput("watchdog busy", bus.busy, 0);
            checkOutput("watchdog wait length", n >= 65535, 1);
            ksStall = 1'b0;
            applyStimulus(16, 16);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/chacha_aead_seq.md
CHACHA_AEAD_SEQ -- requirements
Module: chacha_aead_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 start  input  1  begin one AEAD message; sampled only in IDLE.
REQ-004 aad_len  input  16  AAD byte count, captured on accepted start.
REQ-005 pld_len  input  16  payload byte count, captured on accepted start.
REQ-006 in_valid / in_data  input  1 / 128  host data block, AAD blocks first, then payload blocks.
REQ-007 in_ready  output  1  host block accepted when in_valid && in_ready at an edge.
REQ-008 cfg_we, ks_req  output  1 each  single-cycle pulses to the core.
REQ-009 ks_valid  input  1  keystream block ready from the core.
REQ-010 aad_valid / aad_data / aad_keep  output  1 / 128 / 16  AAD stream to the core.
REQ-011 aad_ready, aad_done  input  1 each  core AAD handshake and per-block completion.
REQ-012 pld_valid / pld_data / pld_keep  output  1 / 128 / 16  payload stream to the core.
REQ-013 pld_ready, pld_done  input  1 each  core payload handshake and per-block completion.
REQ-014 len_valid / len_block  output  1 / 128  length block to the core.
REQ-015 len_ready, lens_done  input  1 each  core length-block handshake and completion.
REQ-016 tag_pre_xor_valid, tagmask_valid  input  1 each  core tag status.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at message completion.
REQ-019 err  output  1  one-cycle watchdog pulse (see Configuration).

Function
REQ-020 The FSM states shall be IDLE, CFG, KS_REQ, KS_WAIT, AAD, AAD_WAIT, PLD, PLD_WAIT, LEN, LEN_WAIT, TAG_WAIT and DONE.
REQ-021 In IDLE, start=1 shall capture both lengths and move the FSM to CFG; start is ignored in all other states.
REQ-022 CFG shall assert cfg_we for exactly one cycle, then go to KS_REQ.
REQ-023 KS_REQ shall assert ks_req for one cycle, then go to KS_WAIT; KS_WAIT shall hold until ks_valid=1.
REQ-024 After the first KS_WAIT, the FSM shall go to AAD if aad_len>0, else to PLD if pld_len>0, else to LEN.
REQ-025 In AAD, the block shall pass through combinationally: aad_valid=in_valid, aad_data=in_data, in_ready=aad_ready; all other valids are 0.
REQ-026 On an accepted AAD transfer, remaining AAD bytes shall decrement by min(rem,16) and the FSM shall go to AAD_WAIT, which holds until aad_done=1.
REQ-027 From AAD_WAIT, the FSM shall return to AAD if bytes remain, else go to PLD (pld_len>0) or LEN.
REQ-028 The keep mask shall be 16'hFFFF when rem>=16, else (1<<rem)-1; for example rem=5 gives 16'h001F.
REQ-029 PLD and PLD_WAIT shall mirror AAD/AAD_WAIT using the pld_* signals.
REQ-030 Before every payload block whose index mod 4 == 0, except index 0, the FSM shall visit KS_REQ/KS_WAIT first (one 64-byte keystream per 4 blocks).
REQ-031 The payload block index shall be 12 bits, counted from 0 per message.
REQ-032 In LEN, len_valid shall be 1 and len_block[63:0] = zero-extended aad_len, len_block[127:64] = zero-extended pld_len.
REQ-033 A transfer with len_ready=1 shall move the FSM to LEN_WAIT, which holds until lens_done=1, then goes to TAG_WAIT.
REQ-034 TAG_WAIT shall hold until both tag_pre_xor_valid and tagmask_valid have been seen; they may arrive in the same or different cycles, and each is latched.
REQ-035 DONE shall assert done for one cycle, then go to IDLE.
REQ-036 A done pulse from the core (aad_done, pld_done or lens_done) arriving in the same cycle as the transfer shall still be honoured (latched); no completion pulse may be lost.
REQ-037 in_ready shall be 0 outside AAD and PLD.

Reset
REQ-038 rst_n=0 shall, immediately and asynchronously, force IDLE, zero all counters and latches, and drive every output to 0 (keep masks 16'h0000).
REQ-039 A reset asserted mid-message shall abandon the message; no done or err pulse shall follow.

Configuration
REQ-040 The macro CHACHA_SEQ_TIMEOUT_EN shall control a 16-bit watchdog.
REQ-041 With CHACHA_SEQ_TIMEOUT_EN defined: the counter shall clear on each state change and increment in the wait states (KS_WAIT, *_WAIT, TAG_WAIT).
REQ-042 With CHACHA_SEQ_TIMEOUT_EN defined: on reaching 16'hFFFF, err shall pulse for one cycle and the FSM shall go to IDLE without a done pulse.
REQ-043 Without CHACHA_SEQ_TIMEOUT_EN: err shall be tied to 0, no counter shall exist, and the wait states shall wait indefinitely.

Verification
REQ-044 aad_len=16, pld_len=16, a core model with immediate responses -> exactly one cfg_we and one ks_req; one AAD and one PLD transfer with keep FFFF; len_block = 128'h0000000000000010_0000000000000010; done pulses once.
REQ-045 aad_len=0, pld_len=20 -> AAD skipped; two payload blocks with keep FFFF then 000F; len_block[127:64]=20 and [63:0]=0.
REQ-046 pld_len=80, aad_len=0 -> 5 payload blocks; ks_req pulses exactly twice, the second one before block index 4.
REQ-047 aad_len=0, pld_len=0 -> CFG, KS, LEN, TAG, DONE; len_block=0; in_ready never asserts.
REQ-048 Reset asserted during PLD_WAIT -> all outputs 0 in the same cycle; a subsequent start completes normally.
REQ-049 With CHACHA_SEQ_TIMEOUT_EN defined, ks_valid held at 0 -> err pulses after 65535 KS_WAIT cycles, the FSM returns to IDLE, and done stays 0.
